me_frame_scheduler: RTL and testbench

ME_FRAME_SCHEDULER -- requirements
Module: me_frame_scheduler

---
 rtl/me_pkg.sv | 43 ++++
 rtl/me_watchdog.sv | 34 +++
 rtl/me_frame_scheduler.sv | 168 ++++++++++++++++
 tb/tb_me_frame_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared constants and helpers for the motion-estimation frame scheduler
//
// Contents:
//   ST_*            FSM state encodings (IDLE, ISSUE, WAIT, WRITE, NEXT, FIN)
//   CUR_MB_WORDS    words per current 16x16 macroblock in engine memory
//   REF_WIN_WORDS   words per reference search window in engine memory
//   RES_* / *_LSB   res_data field layout
//   pack_res()      assembles one result word
package me_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_NEXT  = 3'd4;
  localparam state_t ST_FIN   = 3'd5;

  localparam int CUR_MB_WORDS  = 32;
  localparam int REF_WIN_WORDS = 256;

  localparam int RES_W   = 40;
  localparam int SAD_LSB = 0;
  localparam int SAD_W   = 16;
  localparam int MVX_LSB = 16;
  localparam int MVY_LSB = 22;
  localparam int MV_W    = 6;
  localparam int MBX_LSB = 28;
  localparam int MBY_LSB = 34;
  localparam int MB_W    = 6;

  function automatic logic [RES_W-1:0] pack_res(
    input logic [MB_W-1:0]  mb_y,
    input logic [MB_W-1:0]  mb_x,
    input logic [MV_W-1:0]  mv_y,
    input logic [MV_W-1:0]  mv_x,
    input logic [SAD_W-1:0] sad
  );
    return {mb_y, mb_x, mv_y, mv_x, sad};
  endfunction

endpackage

// File: rtl/me_watchdog.sv
// rtl/me_watchdog.sv - per-macroblock search watchdog counter
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear_i      zero the count (asserted the cycle before the wait window opens)
//   count_i      high for every cycle spent waiting on the engine
//   expired_o    high in the TIMEOUT-th counted cycle
module me_watchdog #(
  parameter int TIMEOUT = 6000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // cnt_q holds the number of wait cycles already completed, so the compare
  // against TIMEOUT-1 fires during the TIMEOUT-th wait cycle itself.
  assign expired_o = count_i && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q <= '0;
    end else if (count_i && !expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/me_frame_scheduler.sv
// rtl/me_frame_scheduler.sv - walks a frame macroblock by macroblock through a motion-estimation engine
//
// Optional feature: define ME_TIMEOUT_EN to build in the WAIT-state watchdog.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cfg_start, cfg_r              frame start pulse, search range code
//   cfg_mb_cols, cfg_mb_rows      frame size in macroblocks
//   busy, frame_done              frame in progress, end-of-frame pulse
//   me_go, me_r                   engine start pulse, latched search range
//   cur_base, ref_base            engine base word addresses
//   me_done, me_sad, me_mv_x/y    engine completion and result
//   res_valid, res_ready, res_data result stream {mb_y, mb_x, mv_y, mv_x, sad}
//   err                           sticky watchdog error
module me_frame_scheduler
  import me_pkg::*;
#(
  parameter int TIMEOUT = 6000,
  parameter int MAX_DIM = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic [1:0]         cfg_r,
  input  logic [MAX_DIM-1:0] cfg_mb_cols,
  input  logic [MAX_DIM-1:0] cfg_mb_rows,
  output logic               busy,
  output logic               frame_done,
  output logic               me_go,
  output logic [1:0]         me_r,
  output logic [15:0]        cur_base,
  output logic [15:0]        ref_base,
  input  logic               me_done,
  input  logic [15:0]        me_sad,
  input  logic [5:0]         me_mv_x,
  input  logic [5:0]         me_mv_y,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [39:0]        res_data,
  output logic               err
);

  state_t             state_q, state_d;
  logic [1:0]         r_q;
  logic [MAX_DIM-1:0] cols_q, rows_q;
  logic [MAX_DIM-1:0] mb_x_q, mb_x_d, mb_y_q, mb_y_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [15:0]        mb_idx;
  logic               frame_empty, last_col, last_row, timeout;

  assign frame_empty = (cfg_mb_cols == '0) || (cfg_mb_rows == '0);
  assign last_col    = (mb_x_q == cols_q - 1'b1);
  assign last_row    = (mb_y_q == rows_q - 1'b1);

  // Counters only move in NEXT, so the bases stay stable from ISSUE through WAIT.
  assign mb_idx   = 16'(mb_y_q) * 16'(cols_q) + 16'(mb_x_q);
  assign cur_base = mb_idx * 16'(CUR_MB_WORDS);
  assign ref_base = mb_idx * 16'(REF_WIN_WORDS);

  assign busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                      (state_q == ST_WRITE) || (state_q == ST_NEXT);
  assign frame_done = (state_q == ST_FIN);
  assign me_go      = (state_q == ST_ISSUE);
  assign res_valid  = (state_q == ST_WRITE);
  assign res_data   = res_q;
  assign me_r       = r_q;

  always_comb begin
    state_d = state_q;
    mb_x_d  = mb_x_q;
    mb_y_d  = mb_y_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          mb_x_d  = '0;
          mb_y_d  = '0;
          state_d = frame_empty ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // A real completion beats a watchdog expiry in the same cycle.
        if (me_done) begin
          res_d   = pack_res(MB_W'(mb_y_q), MB_W'(mb_x_q), me_mv_y, me_mv_x, me_sad);
          state_d = ST_WRITE;
        end else if (timeout) begin
          res_d   = pack_res(MB_W'(mb_y_q), MB_W'(mb_x_q), '0, '0, 16'hFFFF);
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (res_ready) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (last_col) begin
          mb_x_d = '0;
          if (last_row) begin
            mb_y_d  = '0;
            state_d = ST_FIN;
          end else begin
            mb_y_d  = mb_y_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end else begin
          mb_x_d  = mb_x_q + 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      cols_q  <= '0;
      rows_q  <= '0;
      mb_x_q  <= '0;
      mb_y_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mb_x_q  <= mb_x_d;
      mb_y_q  <= mb_y_d;
      res_q   <= res_d;
      if ((state_q == ST_IDLE) && cfg_start) begin
        r_q    <= cfg_r;
        cols_q <= cfg_mb_cols;
        rows_q <= cfg_mb_rows;
      end
    end
  end

`ifdef ME_TIMEOUT_EN
  logic err_q;

  // Only ISSUE leads into WAIT, so clearing there restarts the count per block.
  me_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_q == ST_ISSUE),
    .count_i   (state_q == ST_WAIT),
    .expired_o (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((state_q == ST_WAIT) && timeout && !me_done) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;

  // TIMEOUT feeds only the watchdog; referencing it keeps the parameter
  // interface identical between builds.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

endmodule

// File: tb/tb_me_frame_scheduler.sv
// tb/tb_me_frame_scheduler.sv - scoreboard bench for me_frame_scheduler
module tb_me_frame_scheduler;

`ifdef ME_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 6000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic [1:0]  cfg_r = '0;
  logic [5:0]  cfg_mb_cols = '0, cfg_mb_rows = '0;
  logic        busy, frame_done, me_go, res_valid, err;
  logic [1:0]  me_r;
  logic [15:0] cur_base, ref_base;
  logic        me_done;
  logic [15:0] me_sad;
  logic [5:0]  me_mv_x, me_mv_y;
  logic        res_ready = 1'b0;
  logic [39:0] res_data;

  int n_chk = 0;
  int n_fail = 0;
  int eng_lat = 20;
  bit eng_silent = 0;
  int eng_idx;
  bit eng_abort;

  logic [39:0] sb_q[$];
  logic [15:0] base_q[$];

  me_frame_scheduler #(.TIMEOUT(TO), .MAX_DIM(6)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_r(cfg_r),
    .cfg_mb_cols(cfg_mb_cols), .cfg_mb_rows(cfg_mb_rows),
    .busy(busy), .frame_done(frame_done), .me_go(me_go), .me_r(me_r),
    .cur_base(cur_base), .ref_base(ref_base), .me_done(me_done),
    .me_sad(me_sad), .me_mv_x(me_mv_x), .me_mv_y(me_mv_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] eng_sad(input int idx);
    return 16'(idx * 97 + 5);
  endfunction
  function automatic logic [5:0] eng_mvx(input int idx);
    return 6'(idx + 1);
  endfunction
  function automatic logic [5:0] eng_mvy(input int idx);
    return 6'(30 - idx * 5);
  endfunction
  function automatic logic [39:0] exp_res(input int x, input int y, input int idx, input bit to);
    if (to) return {6'(y), 6'(x), 6'd0, 6'd0, 16'hFFFF};
    return {6'(y), 6'(x), eng_mvy(idx), eng_mvx(idx), eng_sad(idx)};
  endfunction

  // Engine model: answers each me_go after eng_lat cycles, abandons on reset.
  initial begin
    me_done = 1'b0; me_sad = '0; me_mv_x = '0; me_mv_y = '0;
    forever begin
      @(negedge clk);
      if (me_go === 1'b1 && reset === 1'b0 && !eng_silent) begin
        eng_idx = int'(cur_base) / 32;
        eng_abort = 0;
        for (int i = 0; i < eng_lat && !eng_abort; i++) begin
          @(negedge clk);
          if (reset) eng_abort = 1;
        end
        if (!eng_abort) begin
          me_done = 1'b1;
          me_sad  = eng_sad(eng_idx);
          me_mv_x = eng_mvx(eng_idx);
          me_mv_y = eng_mvy(eng_idx);
          @(negedge clk);
          me_done = 1'b0;
        end
      end
    end
  end

  task automatic do_start(input int cols, input int rows, input int r);
    @(negedge clk);
    cfg_mb_cols = 6'(cols);
    cfg_mb_rows = 6'(rows);
    cfg_r = 2'(r);
    cfg_start = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, frame_done, me_go, res_valid, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, frame_done, me_go, res_valid, err});
    end
    n_chk++;
    if ({me_r, cur_base, ref_base, res_data} !== 74'b0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {me_r, cur_base, ref_base, res_data});
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({busy, me_go} !== 2'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b expected 00", {busy, me_go});
    end
  endtask

  task automatic test_frame;
    int go_cnt, fd_cnt, got;
    logic [15:0] eb;
    logic [39:0] er;
    sb_q.delete(); base_q.delete();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++) begin
        sb_q.push_back(exp_res(x, y, y * 2 + x, 0));
        base_q.push_back(16'((y * 2 + x) * 32));
      end
    eng_lat = (TO > 4112) ? 4112 : 20;
    eng_silent = 0;
    res_ready = 1'b1;
    go_cnt = 0; fd_cnt = 0; got = 0;
    do_start(2, 2, 1);
    for (int c = 0; c < 20000 && fd_cnt == 0; c++) begin
      @(negedge clk);
      if (me_go) begin
        go_cnt++;
        eb = (base_q.size() > 0) ? base_q.pop_front() : 16'hDEAD;
        n_chk++;
        if (cur_base !== eb || ref_base !== 16'(eb * 8) || me_r !== 2'd1 || busy !== 1'b1) begin
          n_fail++; $display("FAIL frame_go: got cur %h ref %h r %0d busy %b expected cur %h ref %h r 1 busy 1",
                             cur_base, ref_base, me_r, busy, eb, 16'(eb * 8));
        end
      end
      if (res_valid && res_ready) begin
        got++;
        er = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        n_chk++;
        if (res_data !== er) begin
          n_fail++; $display("FAIL frame_res: got %h expected %h", res_data, er);
        end
      end
      if (frame_done) begin
        fd_cnt++;
        n_chk++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL frame_busy_drop: got %b expected 0", busy);
        end
      end
    end
    repeat (6) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    n_chk++;
    if (go_cnt != 4 || got != 4 || fd_cnt != 1 || err !== 1'b0) begin
      n_fail++; $display("FAIL frame_counts: got go %0d res %0d done %0d err %b expected 4 4 1 0", go_cnt, got, fd_cnt, err);
    end
  endtask

  task automatic test_backpressure;
    int bad, gos, got, fd;
    logic [39:0] held, er;
    sb_q.delete();
    sb_q.push_back(exp_res(0, 0, 0, 0));
    sb_q.push_back(exp_res(0, 1, 1, 0));
    eng_lat = 5;
    res_ready = 1'b0;
    bad = 0; gos = 0; got = 0; fd = 0;
    do_start(1, 2, 2);
    for (int c = 0; c < 200 && !res_valid; c++) @(negedge clk);
    n_chk++;
    if (res_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_wait_valid: got %b expected 1", res_valid);
    end
    held = res_data;
    repeat (10) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== held) bad++;
      if (me_go) gos++;
    end
    n_chk++;
    if (bad != 0 || gos != 0) begin
      n_fail++; $display("FAIL bp_hold: got %0d unstable cycles %0d go pulses expected 0 0", bad, gos);
    end
    res_ready = 1'b1;
    for (int c = 0; c < 200 && fd == 0; c++) begin
      if (res_valid && res_ready) begin
        got++;
        er = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        n_chk++;
        if (res_data !== er) begin
          n_fail++; $display("FAIL bp_res: got %h expected %h", res_data, er);
        end
      end
      if (frame_done) fd = 1;
      @(negedge clk);
    end
    n_chk++;
    if (got != 2 || fd != 1) begin
      n_fail++; $display("FAIL bp_counts: got res %0d done %0d expected 2 1", got, fd);
    end
  endtask

  task automatic test_zero_dim;
    int cols_t[2] = '{0, 4};
    int rows_t[2] = '{3, 0};
    int extra;
    for (int k = 0; k < 2; k++) begin
      do_start(cols_t[k], rows_t[k], 1);
      @(negedge clk);
      n_chk++;
      if ({frame_done, me_go, busy} !== 3'b100) begin
        n_fail++; $display("FAIL zero_dim_%0d: got done/go/busy %b expected 100", k, {frame_done, me_go, busy});
      end
      extra = 0;
      repeat (5) begin
        @(negedge clk);
        if (frame_done || me_go || busy) extra++;
      end
      n_chk++;
      if (extra != 0) begin
        n_fail++; $display("FAIL zero_dim_quiet_%0d: got %0d active cycles expected 0", k, extra);
      end
    end
  endtask

  task automatic test_reset_mid;
    int gos, got, fd;
    logic [39:0] er;
    eng_lat = 30;
    res_ready = 1'b1;
    gos = 0;
    do_start(2, 1, 3);
    for (int c = 0; c < 200 && gos < 2; c++) begin
      @(negedge clk);
      if (me_go) gos++;
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (gos != 2 || res_data !== exp_res(0, 0, 0, 0)) begin
      n_fail++; $display("FAIL rst_mid_pre: got go %0d data %h expected 2 %h", gos, res_data, exp_res(0, 0, 0, 0));
    end
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({busy, frame_done, me_go, res_valid, err, me_r, cur_base, ref_base, res_data} !== 79'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0",
                         {busy, frame_done, me_go, res_valid, err, me_r, cur_base, ref_base, res_data});
    end
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    sb_q.push_back(exp_res(0, 0, 0, 0));
    gos = 0; got = 0; fd = 0;
    eng_lat = 5;
    do_start(1, 1, 2);
    for (int c = 0; c < 200 && fd == 0; c++) begin
      @(negedge clk);
      if (me_go) begin
        gos++;
        n_chk++;
        if (cur_base !== 16'd0 || me_r !== 2'd2) begin
          n_fail++; $display("FAIL rst_restart_go: got cur %h r %0d expected 0 2", cur_base, me_r);
        end
      end
      if (res_valid && res_ready) begin
        got++;
        er = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        n_chk++;
        if (res_data !== er) begin
          n_fail++; $display("FAIL rst_restart_res: got %h expected %h", res_data, er);
        end
      end
      if (frame_done) fd = 1;
    end
    n_chk++;
    if (gos != 1 || got != 1 || fd != 1) begin
      n_fail++; $display("FAIL rst_restart_counts: got go %0d res %0d done %0d expected 1 1 1", gos, got, fd);
    end
  endtask

  task automatic test_busy_start;
    int gos, got, fd;
    logic [39:0] er;
    sb_q.delete();
    sb_q.push_back(exp_res(0, 0, 0, 0));
    eng_lat = 20;
    res_ready = 1'b1;
    gos = 0; got = 0; fd = 0;
    do_start(1, 1, 3);
    @(negedge clk);
    if (me_go) gos++;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_high: got %b expected 1", busy);
    end
    cfg_mb_cols = 6'd3; cfg_mb_rows = 6'd3; cfg_r = 2'd0; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    n_chk++;
    if (me_r !== 2'd3) begin
      n_fail++; $display("FAIL busy_start_r: got %0d expected 3", me_r);
    end
    for (int c = 0; c < 300 && fd == 0; c++) begin
      @(negedge clk);
      if (me_go) gos++;
      if (res_valid && res_ready) begin
        got++;
        er = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        n_chk++;
        if (res_data !== er) begin
          n_fail++; $display("FAIL busy_start_res: got %h expected %h", res_data, er);
        end
      end
      if (frame_done) fd = 1;
    end
    n_chk++;
    if (gos != 1 || got != 1 || fd != 1 || me_r !== 2'd3) begin
      n_fail++; $display("FAIL busy_start_counts: got go %0d res %0d done %0d r %0d expected 1 1 1 3", gos, got, fd, me_r);
    end
  endtask

`ifdef ME_TIMEOUT_EN
  task automatic test_timeout;
    int got, fd;
    logic [39:0] er;
    sb_q.delete();
    sb_q.push_back(exp_res(0, 0, 0, 1));
    sb_q.push_back(exp_res(1, 0, 1, 1));
    eng_silent = 1;
    res_ready = 1'b1;
    got = 0; fd = 0;
    do_start(2, 1, 0);
    @(negedge clk);
    n_chk++;
    if (me_go !== 1'b1) begin
      n_fail++; $display("FAIL to_go: got %b expected 1", me_go);
    end
    repeat (TO) @(negedge clk);
    n_chk++;
    if (err !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL to_early: got err %b valid %b expected 0 0", err, res_valid);
    end
    for (int c = 0; c < 600 && fd == 0; c++) begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        got++;
        er = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        n_chk++;
        if (res_data !== er || err !== 1'b1) begin
          n_fail++; $display("FAIL to_res: got %h err %b expected %h err 1", res_data, err, er);
        end
      end
      if (frame_done) fd = 1;
    end
    n_chk++;
    if (got != 2 || fd != 1 || err !== 1'b1) begin
      n_fail++; $display("FAIL to_counts: got res %0d done %0d err %b expected 2 1 1", got, fd, err);
    end
    eng_silent = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_zero_dim();
    test_reset_mid();
    test_busy_start();
`ifdef ME_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
